// File: rtl/comp_3in_2out_pkg.sv
// ---------------------------------------------------------------------------
// comp_3in_2out_pkg
// Shared constants for the min-sum check-node datapath of the GF(257) 4x24
// LDPC decoder: the position encoding reported with the minimum and the
// default magnitude width used by the check-node units.
// ---------------------------------------------------------------------------
package comp_3in_2out_pkg;

  // Default magnitude width of the check-node datapath.
  localparam int CN_WIDTH = 8;

  // Position encoding of the selected minimum. Code 3 is never produced.
  localparam logic [1:0] IDX_IN1 = 2'd0;
  localparam logic [1:0] IDX_IN2 = 2'd1;
  localparam logic [1:0] IDX_IN3 = 2'd2;

endpackage : comp_3in_2out_pkg

// File: rtl/comp_3in_2out_comp2.sv
// ---------------------------------------------------------------------------
// comp2
// Combinational two-operand unsigned compare. Returns the smaller and larger
// operand and a flag saying which operand was taken as the smaller one.
// Equal operands resolve to the first operand.
//
// Ports:
//   a   in  WIDTH  first operand (wins ties)
//   b   in  WIDTH  second operand
//   lo  out WIDTH  min(a, b)
//   hi  out WIDTH  max(a, b)
//   sel out 1      1 when b is strictly smaller than a (lo came from b)
// ---------------------------------------------------------------------------
module comp2
  import comp_3in_2out_pkg::*;
#(
  parameter int WIDTH = CN_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             sel
);

  // Strict less-than so that a tie keeps the first operand as lo.
  assign sel = (b < a);
  assign lo  = sel ? b : a;
  assign hi  = sel ? a : b;

endmodule : comp2

// File: rtl/comp_3in_2out.sv
// ---------------------------------------------------------------------------
// comp_3in_2out
// Three-input minimum / sub-minimum selector with one register stage.
// Returns the smallest input, the second-smallest input and the position of
// the smallest. On ties the lower position wins the minimum, and the
// sub-minimum then equals the minimum.
//
// Ports:
//   clk       in  1      system clock, rising edge
//   rst       in  1      asynchronous active-high reset
//   in_valid  in  1      qualifies in_1..in_3
//   in_1      in  WIDTH  magnitude, position 0
//   in_2      in  WIDTH  magnitude, position 1
//   in_3      in  WIDTH  magnitude, position 2
//   min_v     out WIDTH  registered minimum
//   submin_v  out WIDTH  registered second-smallest value
//   min_idx   out 2      registered position of min_v (0..2)
//   out_valid out 1      one-cycle pulse per accepted input set
// ---------------------------------------------------------------------------
module comp_3in_2out
  import comp_3in_2out_pkg::*;
#(
  parameter int WIDTH = CN_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  output logic [WIDTH-1:0] min_v,
  output logic [WIDTH-1:0] submin_v,
  output logic [1:0]       min_idx,
  output logic             out_valid
);

  // Stage 1: order the first pair.
  logic [WIDTH-1:0] pair_lo, pair_hi;
  logic             pair_sel;

  comp2 #(.WIDTH(WIDTH)) u_pair (
    .a  (in_1),
    .b  (in_2),
    .lo (pair_lo),
    .hi (pair_hi),
    .sel(pair_sel)
  );

  // Stage 2: pair minimum against in_3. in_3 only wins when strictly smaller,
  // which keeps the first-occurrence rule for the minimum.
  logic [WIDTH-1:0] top_lo, top_hi;
  logic             top_sel;

  comp2 #(.WIDTH(WIDTH)) u_top (
    .a  (pair_lo),
    .b  (in_3),
    .lo (top_lo),
    .hi (top_hi),
    .sel(top_sel)
  );

  // Stage 3: when the pair minimum survives, the runner-up is the smaller of
  // the pair maximum and in_3 (tie resolved to the pair maximum; the value is
  // the same either way).
  logic [WIDTH-1:0] res_lo, res_hi;
  logic             res_sel;

  comp2 #(.WIDTH(WIDTH)) u_resolve (
    .a  (pair_hi),
    .b  (in_3),
    .lo (res_lo),
    .hi (res_hi),
    .sel(res_sel)
  );

  // The overall maximum and its origin are not needed by the check node.
  logic unused_resolve;
  assign unused_resolve = ^{res_hi, res_sel};

  logic [WIDTH-1:0] min_d, submin_d;
  logic [1:0]       idx_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned and infer a latch.
    min_d    = top_lo;
    submin_d = res_lo;
    idx_d    = pair_sel ? IDX_IN2 : IDX_IN1;
    if (top_sel) begin
      // in_3 is the new minimum; the old pair minimum is now second.
      submin_d = top_hi;
      idx_d    = IDX_IN3;
    end
  end

  // Output register stage. Data registers load only on valid input and hold
  // otherwise; out_valid simply follows in_valid by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      min_v     <= '0;
      submin_v  <= '0;
      min_idx   <= IDX_IN1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        min_v    <= min_d;
        submin_v <= submin_d;
        min_idx  <= idx_d;
      end
    end
  end

endmodule : comp_3in_2out

// File: tb/tb_comp_3in_2out.sv
// ---------------------------------------------------------------------------
// tb_comp_3in_2out
// Self-checking bench for comp_3in_2out: directed cases with literal expected
// values, reset behaviour, then a random sweep against a sorting model with a
// one-cycle delay.
// ---------------------------------------------------------------------------
module tb_comp_3in_2out;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_1, in_2, in_3;
  logic [W-1:0] min_v, submin_v;
  logic [1:0]   min_idx;
  logic         out_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected registered outputs, updated by the model when inputs are driven.
  logic [W-1:0] e_min, e_sub;
  logic [1:0]   e_idx;
  logic         e_valid;

  always #5 clk = ~clk;

  comp_3in_2out #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_1     (in_1),
    .in_2     (in_2),
    .in_3     (in_3),
    .min_v    (min_v),
    .submin_v (submin_v),
    .min_idx  (min_idx),
    .out_valid(out_valid)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: sort the three values; minimum is the first, sub-minimum the
  // second; position is the first input holding the minimum value.
  task automatic model(input logic [W-1:0] x1, x2, x3,
                       output logic [W-1:0] m, s, output logic [1:0] idx);
    int v[3];
    int q[$];
    v[0] = int'(x1); v[1] = int'(x2); v[2] = int'(x3);
    q = '{v[0], v[1], v[2]};
    q.sort();
    m = W'(q[0]);
    s = W'(q[1]);
    idx = 2'd0;
    for (int i = 2; i >= 0; i--) if (v[i] == q[0]) idx = 2'(i);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".min"},    int'(min_v),     int'(e_min));
    check({tag, ".submin"}, int'(submin_v),  int'(e_sub));
    check({tag, ".idx"},    int'(min_idx),   int'(e_idx));
    check({tag, ".valid"},  int'(out_valid), int'(e_valid));
    check({tag, ".order"},  int'(min_v <= submin_v), 1);
  endtask

  // At the falling edge: check the outputs of the previous cycle against the
  // model, then drive the next input set and advance the model.
  task automatic step(input string tag, input logic v,
                      input logic [W-1:0] x1, x2, x3);
    @(negedge clk);
    check_model(tag);
    in_valid = v; in_1 = x1; in_2 = x2; in_3 = x3;
    if (v) model(x1, x2, x3, e_min, e_sub, e_idx);
    e_valid = v;
  endtask

  task automatic check_lit(input string tag, input int em, es, ei, ev);
    check({tag, ".min"},    int'(min_v),     em);
    check({tag, ".submin"}, int'(submin_v),  es);
    check({tag, ".idx"},    int'(min_idx),   ei);
    check({tag, ".valid"},  int'(out_valid), ev);
  endtask

  // One valid input set, checked against literal values just after the edge.
  task automatic directed(input string tag, input logic [W-1:0] x1, x2, x3,
                          input int em, es, ei);
    step(tag, 1'b1, x1, x2, x3);
    @(posedge clk);
    #1;
    check_lit(tag, em, es, ei, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_1 = '0; in_2 = '0; in_3 = '0;
    e_min = '0; e_sub = '0; e_idx = '0; e_valid = 1'b0;
    #2;
    check_lit("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    directed("distinct",  37,  12, 200,  12,  37, 1);
    directed("min_in3",   90,  45,   3,   3,  45, 2);
    directed("min_in1",    5, 250, 251,   5, 250, 0);
    directed("tie12",      7,   7,   9,   7,   7, 0);
    directed("tie23",      9,   4,   4,   4,   4, 1);
    directed("tie_all0",   0,   0,   0,   0,   0, 0);
    directed("tie_top",  255, 255, 254, 254, 255, 2);

    // Hold and valid gating: one pulse, then values hold with in_valid low.
    directed("hold_load", 10, 20, 30, 10, 20, 0);
    step("hold1", 1'b0, 1, 1, 1);
    step("hold2", 1'b0, 1, 1, 1);
    @(posedge clk);
    #1;
    check_lit("hold_end", 10, 20, 0, 0);

    // Asynchronous reset between edges, with a valid set presented while
    // reset is high that must be discarded.
    #2;
    rst = 1'b1;
    #1;
    check_lit("async_rst", 0, 0, 0, 0);
    in_valid = 1'b1; in_1 = 1; in_2 = 2; in_3 = 3;
    @(posedge clk);
    #1;
    check_lit("rst_discard", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    e_min = '0; e_sub = '0; e_idx = '0; e_valid = 1'b0;
    directed("post_rst", 200, 100, 150, 100, 150, 1);

    // Random sweep; small values are mixed in to provoke ties.
    for (int n = 0; n < 10000; n++) begin
      logic [W-1:0] r[3];
      logic         v;
      for (int k = 0; k < 3; k++)
        r[k] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3))
                                           : W'($urandom_range(0, 255));
      v = ($urandom_range(0, 3) != 0);
      step("rand", v, r[0], r[1], r[2]);
    end
    step("rand_last", 1'b0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_comp_3in_2out
